// File: rtl/ripple_carry.sv
// ripple_carry: registered WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
// Define RIPPLE_CARRY_OVF_EN to add the registered signed-overflow output ovf.
module ripple_carry_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
`ifdef RIPPLE_CARRY_OVF_EN
    output logic             ovf,
`endif
    output logic             carry
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            ripple_carry_fa u_fa (
                .a (a[i]),
                .b (b[i]),
                .ci(c[i]),
                .s (s[i]),
                .co(c[i+1])
            );
        end
    endgenerate

    always_comb begin
        sum_d   = s;
        carry_d = c[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

`ifdef RIPPLE_CARRY_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carries into and out of the sign bit disagree.
    always_comb ovf_d = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ripple_carry.sv
// tb_ripple_carry: checks 4-bit and 16-bit ripple_carry instances against an arithmetic model.
// Covers reset, directed vectors, hold between edges, mid-stream reset and full/random sweeps.
module tb_ripple_carry;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        c4 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        c16 = 1'b0;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic        carry4, carry16;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

`ifdef RIPPLE_CARRY_OVF_EN
    logic ovf4, ovf16;
    ripple_carry #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .cin(c4),  .sum(sum4),  .ovf(ovf4),  .carry(carry4));
    ripple_carry #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .sum(sum16), .ovf(ovf16), .carry(carry16));
`else
    ripple_carry #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .cin(c4),  .sum(sum4),  .carry(carry4));
    ripple_carry #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .sum(sum16), .carry(carry16));
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signed overflow: true two's-complement result falls outside the w-bit range.
    function automatic logic ovf_model(input int w, input longint a, input longint b, input longint ci);
        longint sa = (a >= (64'sd1 <<< (w - 1))) ? a - (64'sd1 <<< w) : a;
        longint sb = (b >= (64'sd1 <<< (w - 1))) ? b - (64'sd1 <<< w) : b;
        longint r  = sa + sb + ci;
        return (r > (64'sd1 <<< (w - 1)) - 1) || (r < -(64'sd1 <<< (w - 1)));
    endfunction

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [15:0] wa, input logic [15:0] wb, input logic wci);
        logic [4:0]  e4;
        logic [16:0] e16;
        logic        o4, o16;
        a4 = a; b4 = b; c4 = ci;
        a16 = wa; b16 = wb; c16 = wci;
        e4  = 5'(a) + 5'(b) + 5'(ci);
        e16 = 17'(wa) + 17'(wb) + 17'(wci);
        o4  = ovf_model(4, longint'(a), longint'(b), longint'(ci));
        o16 = ovf_model(16, longint'(wa), longint'(wb), longint'(wci));
        @(posedge clk);
        #1;
        check("sum4", sum4, e4[3:0]);
        check("carry4", carry4, e4[4]);
        check("sum16", sum16, e16[15:0]);
        check("carry16", carry16, e16[16]);
`ifdef RIPPLE_CARRY_OVF_EN
        check("ovf4", ovf4, o4);
        check("ovf16", ovf16, o16);
`else
        if (o4 && o16) n_vec += 0;
`endif
    endtask

    logic [3:0] da [6] = '{4'b0101, 4'b0100, 4'b0101, 4'b1111, 4'b0000, 4'b0111};
    logic [3:0] db [6] = '{4'b0010, 4'b1001, 4'b0011, 4'b1111, 4'b0000, 4'b0110};
    logic       dc [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #2;
        check("rst_sum4", sum4, 4'd0);
        check("rst_carry4", carry4, 1'b0);
        check("rst_sum16", sum16, 16'd0);
`ifdef RIPPLE_CARRY_OVF_EN
        check("rst_ovf4", ovf4, 1'b0);
`endif
        rst = 1'b0;
        apply(4'b1111, 4'b0001, 1'b0, 16'hffff, 16'h0001, 1'b0);
        for (int k = 0; k < 6; k++)
            apply(da[k], db[k], dc[k], 16'h7fff, 16'(k), 1'b1);
        // last directed vector left sum4=1101 registered; inputs moved between edges must not show
        a4 = 4'b0011; b4 = 4'b0100; c4 = 1'b1;
        #3;
        check("hold_sum4", sum4, 4'b1101);
        check("hold_carry4", carry4, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_sum4", sum4, 4'd0);
        check("midrst_carry4", carry4, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_sum4", sum4, 4'b1000);
        check("post_rst_carry4", carry4, 1'b0);
        for (int v = 0; v < 512; v++)
            apply(4'(v), 4'(v >> 4), 1'(v >> 8),
                  16'($urandom), 16'($urandom), 1'($urandom));
        for (int v = 0; v < 64; v++)
            apply(4'($urandom), 4'($urandom), 1'($urandom),
                  16'($urandom_range(0, 3) == 0 ? 16'hffff : $urandom), 16'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
